dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 8, meaning the maximum number of consecutive locked debug grants (range 1-255).
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on its negative edge.
REQ-003 SHALL have port resetl  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port cpu_req  input  1  processor requests a data-memory access this cycle.
REQ-005 SHALL have port cpu_we  input  1  processor access is a write (1) or a read (0).
REQ-006 SHALL have ports cpu_addr and cpu_wdata  input  64 each  processor address and write data.
REQ-007 SHALL have port cpu_gnt  output  1  processor access is performed this cycle.
REQ-008 SHALL have port dbg_req  input  1  debug/loader port requests a data-memory access.
REQ-009 SHALL have port dbg_we  input  1  debug access is a write.
REQ-010 SHALL have port dbg_lock  input  1  debug port requests to hold ownership across cycles.
REQ-011 SHALL have ports dbg_addr and dbg_wdata  input  64 each  debug address and write data.
REQ-012 SHALL have port dbg_gnt  output  1  debug access is performed this cycle.
REQ-013 SHALL have ports mem_addr and mem_wdata  output  64 each  shared memory address and write data.
REQ-014 SHALL have ports mem_read and mem_write  output  1 each  shared memory strobes.
REQ-015 SHALL have port mem_rdata  input  64  combinational read data from memory.
REQ-016 SHALL have ports cpu_rvalid/cpu_rdata and dbg_rvalid/dbg_rdata  output  1/64  registered read return.

Function
REQ-017 Grant SHALL be combinational from current requests and state; at most one of cpu_gnt, dbg_gnt SHALL be high in any cycle.
REQ-018 Single requester SHALL be granted in the same cycle; no request, no grant: mem_read=mem_write=0, mem_addr=mem_wdata=0.
REQ-019 Both requesting, no active lock: grant SHALL go to the port not granted last (round-robin via last_winner register; last_winner resets to DBG, so CPU wins first contest).
REQ-020 Granted port SHALL drive mem_addr, mem_wdata; mem_write=we and mem_read=~we of the granted port.
REQ-021 Lock: when dbg is granted with dbg_lock=1, lock becomes active; while active and dbg_req=1, dbg SHALL be granted regardless of cpu_req.
REQ-022 lock_cnt (8-bit) SHALL count consecutive locked dbg grants; after LOCK_MAX of them, if cpu_req=1 the next cycle SHALL grant cpu, after which the lock may resume.
REQ-023 lock_cnt SHALL clear on any cycle dbg is not granted or dbg_lock=0; lock SHALL drop when dbg_req or dbg_lock falls.
REQ-024 On granted read, owner's rvalid SHALL pulse high the following cycle with rdata = mem_rdata captured at grant (latency 1); the other port's rvalid stays 0.
REQ-025 rdata registers SHALL hold their last value when rvalid=0; writes SHALL never produce rvalid.
REQ-026 Non-granted requester SHALL keep its request and signals stable; arbiter SHALL not queue requests.
REQ-027 last_winner SHALL update only on cycles with a grant.

Reset
REQ-028 resetl=0 SHALL immediately clear last_winner to DBG, lock and lock_cnt to 0, both rvalid to 0, both rdata to 0; grants remain combinational from requests.
REQ-029 Reset asserted mid-lock or with a read in flight SHALL cancel the pending rvalid and the lock.

Verification
REQ-030 Reset then cpu_req=1 read addr 0x10, mem_rdata=0xAB -> cpu_gnt=1 same cycle, cpu_rvalid=1, cpu_rdata=0xAB next cycle.
REQ-031 cpu_req=dbg_req=1 for 4 cycles, no lock -> grants CPU,DBG,CPU,DBG.
REQ-032 LOCK_MAX=8, dbg_lock=dbg_req=cpu_req=1 for 12 cycles -> DBG x8, CPU x1, DBG x3.
REQ-033 dbg write addr 0x20 data 0x55 alone -> mem_write=1, mem_addr=0x20, mem_wdata=0x55, no dbg_rvalid.
REQ-034 resetl low during locked debug read -> dbg_rvalid stays 0, lock cleared; next contest grants CPU.
REQ-035 no requests -> both grants 0, mem strobes 0, rvalid 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU and debug/loader share one combinational memory port.
// Round-robin on contention, optional bounded debug lock, registered one-cycle read return.
module dmem_arbiter #(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic        cpu_gnt,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic        dbg_lock,
  input  logic [63:0] dbg_addr,
  input  logic [63:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_rdata,
  output logic        cpu_rvalid,
  output logic [63:0] cpu_rdata,
  output logic        dbg_rvalid,
  output logic [63:0] dbg_rdata
);

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_e;

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  owner_e      last_winner_q, last_winner_d;
  logic        lock_q, lock_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        dbg_rvalid_q, dbg_rvalid_d;
  logic [63:0] cpu_rdata_q, cpu_rdata_d;
  logic [63:0] dbg_rdata_q, dbg_rdata_d;

  // Grant decision. A held lock yields to the CPU once LOCK_MAX locked grants have gone by.
  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (cpu_req && dbg_req) begin
      if (lock_q) begin
        if (lock_cnt_q >= LOCK_MAX_C) cpu_gnt = 1'b1;
        else                          dbg_gnt = 1'b1;
      end else if (last_winner_q == OWNER_DBG) begin
        cpu_gnt = 1'b1;
      end else begin
        dbg_gnt = 1'b1;
      end
    end else begin
      cpu_gnt = cpu_req;
      dbg_gnt = dbg_req;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_read  = ~cpu_we;
      mem_write = cpu_we;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_read  = ~dbg_we;
      mem_write = dbg_we;
    end
  end

  always_comb begin
    last_winner_d = last_winner_q;
    if (cpu_gnt)      last_winner_d = OWNER_CPU;
    else if (dbg_gnt) last_winner_d = OWNER_DBG;

    // Lock survives the forced CPU slot so the debug port resumes ownership afterwards.
    lock_d = (dbg_req && dbg_lock) ? (lock_q || dbg_gnt) : 1'b0;

    lock_cnt_d = 8'd0;
    if (dbg_gnt && dbg_lock) lock_cnt_d = (lock_cnt_q == 8'hFF) ? lock_cnt_q : lock_cnt_q + 8'd1;

    cpu_rvalid_d = cpu_gnt && !cpu_we;
    dbg_rvalid_d = dbg_gnt && !dbg_we;
    cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
    dbg_rdata_d  = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(negedge CLK or negedge resetl) begin
    if (!resetl) begin
      last_winner_q <= OWNER_DBG;
      lock_q        <= 1'b0;
      lock_cnt_q    <= 8'd0;
      cpu_rvalid_q  <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      cpu_rdata_q   <= '0;
      dbg_rdata_q   <= '0;
    end else begin
      last_winner_q <= last_winner_d;
      lock_q        <= lock_d;
      lock_cnt_q    <= lock_cnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dbg_rdata_q   <= dbg_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule
